two_complementer: RTL and testbench

TWO_COMPLEMENTER -- requirements
Module: two_complementer

---
 rtl/two_comp_pkg.sv | 15 +
 rtl/two_comp_bit_counter.sv | 38 +++
 rtl/two_complementer.sv | 86 ++++++++
 tb/tb_two_complementer.sv | 108 ++++++++++
 4 files changed

// File: rtl/two_comp_pkg.sv
// two_comp_pkg
//   Shared definitions for the serial two's-complementer:
//     state_t          - FSM state encoding (S_PASS, S_INVERT)
//     WORD_LEN_DEFAULT - default serial word length used when word restart
//                        (TWO_COMP_WORD_RESTART_EN) is compiled in.
package two_comp_pkg;

  typedef enum logic [0:0] {
    S_PASS   = 1'b0,  // no 1 seen yet in the current word
    S_INVERT = 1'b1   // a 1 has been seen; remaining bits are inverted
  } state_t;

  localparam int unsigned WORD_LEN_DEFAULT = 16;

endpackage : two_comp_pkg

// File: rtl/two_comp_bit_counter.sv
// two_comp_bit_counter
//   Counts serial bit positions 0..WORD_LEN-1 and flags the last bit of each
//   word so the complementer can restart its FSM on word boundaries.
//   Ports:
//     clk   - clock, counter advances on every rising edge outside reset
//     reset - asynchronous active-low reset, clears the count to 0
//     wrap  - high while the current bit is bit WORD_LEN-1 (the edge that
//             consumes it wraps the count back to 0)
module two_comp_bit_counter
  import two_comp_pkg::*;
#(
  parameter int unsigned WORD_LEN = WORD_LEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic wrap
);

  localparam int unsigned     CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : two_comp_bit_counter

// File: rtl/two_complementer.sv
// two_complementer
//   Serial two's-complementer, LSB first. Bits pass through unchanged up to
//   and including the first 1; every later bit is inverted. The result is
//   registered, so out shows the bit sampled at edge k from just after edge k.
//   Ports:
//     inp   - serial operand bit, LSB first
//     clk   - clock
//     reset - asynchronous active-low reset (state S_PASS, out = 0)
//     out   - registered serial result bit
//   Configuration macro: TWO_COMP_WORD_RESTART_EN
//     defined   - a bit counter restarts the FSM every WORD_LEN bits, so
//                 back-to-back words are complemented independently
//     undefined - the stream is one unbounded word until reset; WORD_LEN
//                 is unused
module two_complementer
  import two_comp_pkg::*;
#(
  parameter int unsigned WORD_LEN = WORD_LEN_DEFAULT
) (
  input  logic inp,
  input  logic clk,
  input  logic reset,
  output logic out
);

  state_t state_q;
  state_t state_d;
  logic   out_q;
  logic   out_d;
  logic   word_end;

`ifdef TWO_COMP_WORD_RESTART_EN
  two_comp_bit_counter #(
    .WORD_LEN (WORD_LEN)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .wrap  (word_end)
  );
`else
  // No word boundaries: the FSM only leaves S_INVERT through reset.
  assign word_end = 1'b0;

  logic unused_word_len;
  assign unused_word_len = ^WORD_LEN;
`endif

  always_comb begin
    out_d   = inp;
    state_d = state_q;
    case (state_q)
      S_PASS: begin
        out_d = inp;
        if (inp) begin
          state_d = S_INVERT;
        end
      end
      S_INVERT: begin
        out_d   = ~inp;
        state_d = S_INVERT;
      end
      default: begin
        out_d   = inp;
        state_d = S_PASS;
      end
    endcase
    // The last bit of a word is still processed by the current state; only
    // the state for the following bit is forced back to S_PASS.
    if (word_end) begin
      state_d = S_PASS;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_PASS;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule : two_complementer

// File: tb/tb_two_complementer.sv
// tb_two_complementer
//   Directed bench for two_complementer: reset behaviour, the reference
//   vector 0x7668 -> 0x8998, boundary words, mid-word reset and back-to-back
//   words. Expected words are hand-computed two's complements.
module tb_two_complementer;

  logic inp;
  logic clk;
  logic reset;
  logic out;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  two_complementer #(
    .WORD_LEN (16)
  ) dut (
    .inp   (inp),
    .clk   (clk),
    .reset (reset),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic obs, input logic expv, input string tag);
    check_count++;
    assert (obs === expv) pass_count++;
    else begin
      fail_count++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Stream nbits of w LSB first; check out after each edge against expw.
  task automatic send_word(input logic [15:0] w, input logic [15:0] expw,
                           input int nbits, input string tag);
    logic [15:0] got;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      inp = w[i];
      @(posedge clk);
      #1;
      got[i] = out;
      check(out, expw[i], $sformatf("%s bit%0d", tag, i));
    end
    $display("word %s in=%04h bits=%0d out=%04h exp=%04h", tag, w, nbits,
             got, expw);
  endtask

  // Pulse reset between clock edges and confirm out clears asynchronously.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check(out, 1'b0, {tag, " async clear"});
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    inp   = 1'b0;
    reset = 1'b0;

    // Reset held low with inp = 1 and clk toggling: out must stay 0.
    #1;
    inp = 1'b1;
    check(out, 1'b0, "reset t1");
    #5;
    check(out, 1'b0, "reset t6");
    #10;
    check(out, 1'b0, "reset t16");
    @(negedge clk);
    reset = 1'b1;

    // Reference vector; first bit after release handled in S_PASS.
    send_word(16'h7668, 16'h8998, 16, "ref_7668");
    pulse_reset("after_ref");

    send_word(16'h0000, 16'h0000, 16, "zero");
    pulse_reset("after_zero");
    send_word(16'h0001, 16'hFFFF, 16, "one");
    pulse_reset("after_one");
    send_word(16'h8000, 16'h8000, 16, "most_neg");

    // Abandon 0x7668 after bit 5 (state is S_INVERT there), then 0x0004.
    pulse_reset("before_partial");
    send_word(16'h7668, 16'h0018, 6, "partial_7668");
    pulse_reset("mid_word");
    send_word(16'h0004, 16'hFFFC, 16, "after_midreset");

    // Back-to-back words with no reset between them.
    pulse_reset("before_b2b");
    send_word(16'h0001, 16'hFFFF, 16, "b2b_first");
`ifdef TWO_COMP_WORD_RESTART_EN
    send_word(16'h0002, 16'hFFFE, 16, "b2b_second");
`else
    send_word(16'h0002, 16'hFFFD, 16, "b2b_second");
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_two_complementer
